// File: rtl/stb_dcache_pkg.sv
// Shared types and geometry helpers for the write-through data cache write controller.
package stb_dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_WR,
    ST_ACK
  } dcache_wr_state_e;

  function automatic int calc_idx_w(input int num_entries);
    return $clog2(num_entries);
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int num_entries);
    return addr_width - $clog2(num_entries) - 2;
  endfunction

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_NUM_ENTRIES = 16;
  localparam int DEF_TAG_W       = calc_tag_w(DEF_ADDR_WIDTH, DEF_NUM_ENTRIES);

  // Entry layout for the default geometry.
  typedef struct packed {
    logic                      valid;
    logic [DEF_TAG_W-1:0]      tag;
    logic [DEF_DATA_WIDTH-1:0] data;
  } dcache_entry_t;

endpackage

// File: rtl/stb_dcache_wr_ctrl_if.sv
// Bus bundle for the cache write controller: store-buffer side, memory side, LSU read port, flush.
interface stb_dcache_wr_ctrl_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
  logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
  logic                      stb2dcache_w_en;
  logic                      stb2dcache_req;
  logic                      dmem_sel_i;
  logic                      dcache2stb_ack;

  logic [ADDR_WIDTH-1:0]     dcache2mem_addr;
  logic [DATA_WIDTH-1:0]     dcache2mem_wdata;
  logic [BYTE_SEL_WIDTH-1:0] dcache2mem_sel_byte;
  logic                      dcache2mem_req;
  logic                      dcache2mem_w_en;
  logic                      mem2dcache_ack;

  logic                      lsu2dcache_rd_req;
  logic [ADDR_WIDTH-1:0]     lsu2dcache_rd_addr;
  logic [DATA_WIDTH-1:0]     dcache2lsu_rdata;
  logic                      dcache2lsu_rd_hit;

  logic                      dcache_flush;

  modport master (
    output stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte, stb2dcache_w_en,
           stb2dcache_req, dmem_sel_i, mem2dcache_ack, lsu2dcache_rd_req,
           lsu2dcache_rd_addr, dcache_flush,
    input  dcache2stb_ack, dcache2mem_addr, dcache2mem_wdata, dcache2mem_sel_byte,
           dcache2mem_req, dcache2mem_w_en, dcache2lsu_rdata, dcache2lsu_rd_hit
  );

  modport slave (
    input  stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte, stb2dcache_w_en,
           stb2dcache_req, dmem_sel_i, mem2dcache_ack, lsu2dcache_rd_req,
           lsu2dcache_rd_addr, dcache_flush,
    output dcache2stb_ack, dcache2mem_addr, dcache2mem_wdata, dcache2mem_sel_byte,
           dcache2mem_req, dcache2mem_w_en, dcache2lsu_rdata, dcache2lsu_rd_hit
  );
endinterface

// File: rtl/stb_dcache_wr_ctrl_byte_merge.sv
// Combinational byte-lane merge of a new word into an old word under byte enables.
module dcache_byte_merge #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0]     old_word,
  input  logic [DATA_WIDTH-1:0]     new_word,
  input  logic [BYTE_SEL_WIDTH-1:0] sel_byte,
  output logic [DATA_WIDTH-1:0]     merged
);

  always_comb begin
    merged = old_word;
    for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
      if (sel_byte[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
  end

endmodule

// File: rtl/stb_dcache_wr_ctrl.sv
// Write-through, direct-mapped, word-granular data cache write controller with registered LSU read port.
// Optional macro DCACHE_WR_BYPASS_EN forwards the LOOKUP write to a same-cycle read of that entry.
module stb_dcache_wr_ctrl
  import stb_dcache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int NUM_ENTRIES    = 16
) (
  input logic             clk,
  input logic             rst,
  stb_dcache_wr_ctrl_if.slave bus
);

  localparam int IDX_W = calc_idx_w(NUM_ENTRIES);
  localparam int TAG_W = calc_tag_w(ADDR_WIDTH, NUM_ENTRIES);

  dcache_wr_state_e state_q, state_d;
  logic             latch_en;
  logic             mem_req;
  logic             stb_ack;

  logic [ADDR_WIDTH-1:0]     lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic [BYTE_SEL_WIDTH-1:0] lat_sel;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  data_q [NUM_ENTRIES];

  logic [IDX_W-1:0]      lat_idx;
  logic [TAG_W-1:0]      lat_tag;
  logic                  wr_hit;
  logic                  arr_wr;
  logic [DATA_WIDTH-1:0] wr_word;

  logic [IDX_W-1:0]      rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_hit_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic                  rd_hit_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic                  rd_addr_unused;

  assign lat_idx = lat_addr[IDX_W+1:2];
  assign lat_tag = lat_addr[ADDR_WIDTH-1:IDX_W+2];
  assign wr_hit  = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
  // Hits merge in place; only full-word misses allocate, partial misses go to memory only.
  assign arr_wr  = (state_q == ST_LOOKUP) && (wr_hit || (&lat_sel));

  dcache_byte_merge #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH)
  ) u_merge (
    .old_word (data_q[lat_idx]),
    .new_word (lat_wdata),
    .sel_byte (lat_sel),
    .merged   (wr_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    mem_req  = 1'b0;
    stb_ack  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.stb2dcache_req) begin
          if (bus.stb2dcache_w_en && bus.dmem_sel_i) begin
            latch_en = 1'b1;
            state_d  = ST_LOOKUP;
          end else begin
            state_d  = ST_ACK;
          end
        end
      end
      ST_LOOKUP: state_d = ST_MEM_WR;
      ST_MEM_WR: begin
        mem_req = 1'b1;
        if (bus.mem2dcache_ack) state_d = ST_ACK;
      end
      ST_ACK: begin
        stb_ack = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.dcache2stb_ack      = stb_ack;
  assign bus.dcache2mem_req      = mem_req;
  assign bus.dcache2mem_w_en     = mem_req;
  assign bus.dcache2mem_addr     = lat_addr;
  assign bus.dcache2mem_wdata    = lat_wdata;
  assign bus.dcache2mem_sel_byte = lat_sel;

  // Latched store fields double as the memory write fields, so they stay stable during MEM_WR.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_sel   <= '0;
    end else if (latch_en) begin
      lat_addr  <= bus.stb2dcache_addr;
      lat_wdata <= bus.stb2dcache_wdata;
      lat_sel   <= bus.stb2dcache_sel_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.dcache_flush) valid_q <= '0;
    else if (arr_wr)             valid_q[lat_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (arr_wr) begin
      tag_q[lat_idx]  <= lat_tag;
      data_q[lat_idx] <= wr_word;
    end
  end

  assign rd_idx         = bus.lsu2dcache_rd_addr[IDX_W+1:2];
  assign rd_tag         = bus.lsu2dcache_rd_addr[ADDR_WIDTH-1:IDX_W+2];
  assign rd_addr_unused = ^bus.lsu2dcache_rd_addr[1:0];

`ifdef DCACHE_WR_BYPASS_EN
  logic rd_byp;
  // A flush in the same cycle suppresses forwarding, matching the fact that no valid bit gets set.
  assign rd_byp    = bus.lsu2dcache_rd_req && arr_wr && !bus.dcache_flush &&
                     (rd_idx == lat_idx) && (rd_tag == lat_tag);
  assign rd_hit_c  = rd_byp || (bus.lsu2dcache_rd_req && valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag));
  assign rd_word_c = rd_byp ? wr_word : data_q[rd_idx];
`else
  assign rd_hit_c  = bus.lsu2dcache_rd_req && valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_word_c = data_q[rd_idx];
`endif

  // Stage p1: registered read result; data holds while no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hit_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      rd_hit_p1 <= rd_hit_c;
      if (bus.lsu2dcache_rd_req) rdata_p1 <= rd_word_c;
    end
  end

  assign bus.dcache2lsu_rd_hit = rd_hit_p1;
  assign bus.dcache2lsu_rdata  = rdata_p1;

endmodule

// File: doc/stb_dcache_wr_ctrl.md
# stb_dcache_wr_ctrl

Write-side controller of the data cache, directly downstream of `store_buffer_top`. Accepts one drained store at a time on the `stb2dcache_*` handshake, updates a small direct-mapped, word-granular, write-through cache array and forwards every store to the memory bus. It acknowledges the store buffer only after memory has accepted the write. It also provides a one-cycle registered read port for the LSU.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width
- `BYTE_SEL_WIDTH`, 4, byte enables per word (DATA_WIDTH/8)
- `NUM_ENTRIES`, 16, cache words (power of 2); `IDX_W = $clog2(NUM_ENTRIES)`, `TAG_W = ADDR_WIDTH-IDX_W-2`
- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stb2dcache_addr`  in  ADDR_WIDTH  store byte address
- `stb2dcache_wdata`  in  DATA_WIDTH  store data
- `stb2dcache_sel_byte`  in  BYTE_SEL_WIDTH  byte enables
- `stb2dcache_w_en`  in  1  write enable
- `stb2dcache_req`  in  1  store request, held until ack
- `dmem_sel_i`  in  1  target is data memory
- `dcache2stb_ack`  out  1  one-cycle store-complete pulse
- `dcache2mem_addr` / `_wdata` / `_sel_byte`  out  ADDR_WIDTH / DATA_WIDTH / BYTE_SEL_WIDTH  memory write fields
- `dcache2mem_req`, `dcache2mem_w_en`  out  1  memory write request, held until ack
- `mem2dcache_ack`  in  1  memory accepted the write
- `lsu2dcache_rd_req`  in  1  read request
- `lsu2dcache_rd_addr`  in  ADDR_WIDTH  read byte address
- `dcache2lsu_rdata`  out  DATA_WIDTH  read data, registered
- `dcache2lsu_rd_hit`  out  1  read hit, registered
- `dcache_flush`  in  1  invalidate all entries

## Operation
- Address split: index = `addr[IDX_W+1:2]`; tag = `addr[ADDR_WIDTH-1:IDX_W+2]`; `addr[1:0]` ignored.
- Per entry: valid bit, tag, data word. Only valid bits are reset.
- FSM states: IDLE, LOOKUP, MEM_WR, ACK.
- **IDLE**
  - `stb2dcache_req && stb2dcache_w_en && dmem_sel_i`: latch addr, wdata and sel_byte; go to LOOKUP.
  - `stb2dcache_req` with `w_en=0` or `dmem_sel_i=0`: go to ACK with no array or memory action.
- **LOOKUP** (1 cycle). Hit = valid && tag equal.
  - Hit: merge the enabled bytes into the entry.
  - Miss with `sel_byte` all ones: allocate the entry (write tag and data, set valid).
  - Miss with partial `sel_byte`: no allocate.
  - All cases go to MEM_WR.
- **MEM_WR**
  - Drive `dcache2mem_req=1` and `dcache2mem_w_en=1` with the latched fields.
  - Stay until `mem2dcache_ack` is sampled high, then go to ACK.
- **ACK**: `dcache2stb_ack=1` for exactly one cycle; go to IDLE. A `stb2dcache_req` seen in the following IDLE cycle is a new store.
- **Read port**
  - Active in every state.
  - `rd_hit` = `rd_req` && valid && tag equal; `rdata` = entry data.
  - Both are registered. When `rd_req=0`, `rd_hit` goes to 0 and `rdata` holds its value.
- **Flush**
  - `dcache_flush` clears all valid bits at the next edge.
  - If flush coincides with LOOKUP, the flush wins: no valid bit is set. The store still goes to memory and is acked.

## Timing
- Reset values: state IDLE; all valid bits 0; `dcache2stb_ack`, `dcache2mem_req`, `dcache2mem_w_en`, `dcache2lsu_rd_hit` = 0; `dcache2mem_addr/wdata/sel_byte`, `dcache2lsu_rdata` = 0.
- Reset mid-operation (any state) aborts to IDLE; an outstanding memory request is dropped.
- Store latency with memory ack in the first MEM_WR cycle: req sampled at edge 0 → LOOKUP → MEM_WR → ack pulse in cycle 3. Each extra memory wait cycle adds 1.
- Read latency: 1 cycle. A read in the same cycle as a LOOKUP write to the same entry returns the pre-write contents (see Configuration).
- Memory fields are stable while `dcache2mem_req=1`.

## Configuration
- `DCACHE_WR_BYPASS_EN`
  - Defined: a read hitting the entry being written in LOOKUP returns the merged or allocated data with `rd_hit=1`. The flush-wins rule still applies.
  - Undefined: read-before-write behaviour.

## Structure
- Shared package `stb_dcache_pkg`: FSM state enum `dcache_wr_state_e`, entry struct (valid, tag, data), and the `IDX_W`/`TAG_W` derivation functions.
- Sub-module `dcache_byte_merge`: combinational merge of old word, new word and `sel_byte`; reused by the bypass path.

## Test plan
- Reset, then read 0x40 → `rd_hit=0`; all outputs at their reset values.
- Store 0x40 / 0xAAAABBBB / 1111, memory acks immediately → ack in cycle 3; memory sees 0x40 / 0xAAAABBBB; next read of 0x40 → hit, 0xAAAABBBB.
- Partial store 0x40 / 0x000000CC / 0001 onto that entry → read returns 0xAAAABBCC. Partial store to 0x80 (miss) → read 0x80 misses; memory still written.
- Memory ack delayed 5 cycles → `dcache2mem_req` held for 5 cycles with stable fields; `dcache2stb_ack` is a single pulse.
- Flush asserted during LOOKUP of a full-word store to 0x100 → subsequent read of 0x100 misses; store still acked.
- Read 0x40 in the LOOKUP cycle of a store to 0x40 → old data without `DCACHE_WR_BYPASS_EN`, new data with it.
